// File: rtl/rect_painter.sv
// Rectangle painter: walks a clamped rectangle in STEP-sized cells, row-major,
// emitting one coloured pixel write per cycle into a downstream FIFO.
module rect_painter #(
    parameter int unsigned HPOS_WIDTH = 10,
    parameter int unsigned VPOS_WIDTH = 10,
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned STEP       = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [HPOS_WIDTH-1:0] x0,
    input  logic [HPOS_WIDTH-1:0] x1,
    input  logic [VPOS_WIDTH-1:0] y0,
    input  logic [VPOS_WIDTH-1:0] y1,
    input  logic [2:0]            color,
    input  logic                  full,
    output logic                  push,
    output logic [HPOS_WIDTH-1:0] hpos,
    output logic [VPOS_WIDTH-1:0] vpos,
    output logic [2:0]            rgb_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned HW = HPOS_WIDTH + 1;
    localparam int unsigned VW = VPOS_WIDTH + 1;
    localparam logic [HW-1:0] X_MAX  = HW'(H_DISPLAY - 1);
    localparam logic [VW-1:0] Y_MAX  = VW'(V_DISPLAY - 1);
    localparam logic [HW-1:0] STEP_H = HW'(STEP);
    localparam logic [VW-1:0] STEP_V = VW'(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HPOS_WIDTH-1:0] x0_q;
    logic [HPOS_WIDTH-1:0] x1_q;
    logic [VPOS_WIDTH-1:0] y0_q;
    logic [VPOS_WIDTH-1:0] y1_q;
    logic [2:0]            color_q;

    logic [HW-1:0] x1_clamp;
    logic [VW-1:0] y1_clamp;
    logic          invalid;
    logic [HW-1:0] h_step;
    logic [VW-1:0] v_step;
    logic          h_adv;
    logic          v_adv;
    logic          accept;

    // Clamp and validity are evaluated on the captured corners during LOAD.
    always_comb begin
        x1_clamp = (HW'(x1_q) > X_MAX) ? X_MAX : HW'(x1_q);
        y1_clamp = (VW'(y1_q) > Y_MAX) ? Y_MAX : VW'(y1_q);
        invalid  = (HW'(x0_q) > x1_clamp) || (VW'(y0_q) > y1_clamp);
    end

    // In DRAW, x1_q/y1_q already hold the clamped corners; sums are one bit wider.
    always_comb begin
        h_step = HW'(hpos) + STEP_H;
        v_step = VW'(vpos) + STEP_V;
        h_adv  = (h_step <= HW'(x1_q));
        v_adv  = (v_step <= VW'(y1_q));
    end

    // A rejected request keeps busy high through its err cycle, so start is
    // only taken once busy has dropped.
    assign accept = start && !busy;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = invalid ? IDLE : DRAW;
            DRAW: begin
                push = !full;
                if (!full && !h_adv && !v_adv) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            hpos    <= '0;
            vpos    <= '0;
            rgb_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE) || ((state == LOAD) && invalid);
            done  <= (state_nxt == FIN);
            err   <= (state == LOAD) && invalid;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0_q    <= x0;
                        x1_q    <= x1;
                        y0_q    <= y0;
                        y1_q    <= y1;
                        color_q <= color;
                    end
                end
                LOAD: begin
                    x1_q <= HPOS_WIDTH'(x1_clamp);
                    y1_q <= VPOS_WIDTH'(y1_clamp);
                    if (!invalid) begin
                        hpos    <= x0_q;
                        vpos    <= y0_q;
                        rgb_out <= color_q;
                    end
                end
                DRAW: begin
                    // Coordinates move only on an accepted write.
                    if (push) begin
                        if (h_adv) begin
                            hpos <= HPOS_WIDTH'(h_step);
                        end else if (v_adv) begin
                            hpos <= x0_q;
                            vpos <= VPOS_WIDTH'(v_step);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_painter.sv
// Directed testbench for rect_painter: one task per scenario with inline
// comparisons against hand-computed expectations.
module tb_rect_painter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [9:0] x0, x1, y0, y1;
    logic [2:0] color;
    logic       full;
    logic       push;
    logic [9:0] hpos, vpos;
    logic [2:0] rgb_out;
    logic       busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [9:0] px[$];
    logic [9:0] py[$];
    logic [2:0] pc[$];
    int         pcyc[$];
    int         cyc;
    int         done_cnt, err_cnt, busy_cnt, done_cyc, err_cyc;
    logic       s_push, s_busy, s_done, s_err;
    logic [9:0] s_hpos, s_vpos;
    logic [2:0] s_rgb;

    always #5 clk = ~clk;

    rect_painter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .color   (color),
        .full    (full),
        .push    (push),
        .hpos    (hpos),
        .vpos    (vpos),
        .rgb_out (rgb_out),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    task automatic clear_log();
        px.delete(); py.delete(); pc.delete(); pcyc.delete();
        cyc = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0;
        done_cyc = -1; err_cyc = -1;
    endtask

    // Sample mid-cycle with inputs settled, then advance to just after the next edge.
    task automatic step();
        #1;
        s_push = push; s_busy = busy; s_done = done; s_err = err;
        s_hpos = hpos; s_vpos = vpos; s_rgb = rgb_out;
        if (push === 1'b1) begin
            px.push_back(hpos); py.push_back(vpos); pc.push_back(rgb_out);
            pcyc.push_back(cyc);
        end
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (busy === 1'b1) busy_cnt++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rect(input int ax0, input int ax1, input int ay0,
                            input int ay1, input int acol);
        x0 = 10'(ax0); x1 = 10'(ax1); y0 = 10'(ay0); y1 = 10'(ay1);
        color = 3'(acol);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; full = 1'b0;
        set_rect(0, 0, 0, 0, 0);
        clear_log();
        step(); step();
        step();
        checks++; if (s_push !== 1'b0) begin errors++; $display("FAIL reset_push got=%b exp=0", s_push); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
        checks++; if (s_done !== 1'b0 || s_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b exp=00", s_done, s_err); end
        checks++; if (s_hpos !== 10'd0 || s_vpos !== 10'd0 || s_rgb !== 3'd0) begin
            errors++; $display("FAIL reset_coords got=(%0d,%0d,%0d) exp=(0,0,0)", s_hpos, s_vpos, s_rgb);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int ex[4] = '{0, 8, 0, 8};
        int ey[4] = '{0, 0, 8, 8};
        clear_log();
        set_rect(0, 15, 0, 15, 5);
        start = 1'b1;
        step();
        start = 1'b0;
        set_rect(500, 3, 400, 2, 2);   // late input changes must not matter
        for (int i = 0; i < 10; i++) step();
        checks++; if (px.size() != 4) begin errors++; $display("FAIL basic_count got=%0d exp=4", px.size()); end
        for (int i = 0; i < 4 && i < px.size(); i++) begin
            checks++;
            if (px[i] !== 10'(ex[i]) || py[i] !== 10'(ey[i]) || pc[i] !== 3'd5) begin
                errors++;
                $display("FAIL basic_pix%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,5)", i, px[i], py[i], pc[i], ex[i], ey[i]);
            end
        end
        checks++; if (pcyc.size() > 0 && pcyc[0] != 2) begin errors++; $display("FAIL basic_first_push_cycle got=%0d exp=2", pcyc[0]); end
        checks++; if (done_cnt != 1 || done_cyc != 6) begin errors++; $display("FAIL basic_done got=cnt%0d@%0d exp=cnt1@6", done_cnt, done_cyc); end
        checks++; if (busy_cnt != 6) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=6", busy_cnt); end
    endtask

    task automatic test_clamp();
        clear_log();
        set_rect(632, 700, 0, 7, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (px.size() != 1) begin errors++; $display("FAIL clamp_count got=%0d exp=1", px.size()); end
        checks++; if (px.size() > 0 && (px[0] !== 10'd632 || py[0] !== 10'd0 || pc[0] !== 3'd3)) begin
            errors++; $display("FAIL clamp_pix got=(%0d,%0d,%0d) exp=(632,0,3)", px[0], py[0], pc[0]);
        end
        checks++; if (done_cnt != 1 || done_cyc != 3) begin errors++; $display("FAIL clamp_done got=cnt%0d@%0d exp=cnt1@3", done_cnt, done_cyc); end
    endtask

    task automatic test_invalid();
        clear_log();
        set_rect(16, 8, 0, 0, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checks++; if (px.size() != 0) begin errors++; $display("FAIL invalid_pushes got=%0d exp=0", px.size()); end
        checks++; if (err_cnt != 1 || err_cyc != 2) begin errors++; $display("FAIL invalid_err got=cnt%0d@%0d exp=cnt1@2", err_cnt, err_cyc); end
        checks++; if (busy_cnt != 2) begin errors++; $display("FAIL invalid_busy_cycles got=%0d exp=2", busy_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL invalid_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_full();
        clear_log();
        set_rect(0, 23, 0, 0, 6);
        for (int i = 0; i < 13; i++) begin
            start = (i == 0);
            full  = (i >= 3 && i <= 7);
            step();
            if (i >= 3 && i <= 7) begin
                checks++;
                if (s_hpos !== 10'd8 || s_push !== 1'b0) begin
                    errors++; $display("FAIL full_hold_c%0d got=hpos%0d push%b exp=hpos8 push0", i, s_hpos, s_push);
                end
            end
        end
        full = 1'b0;
        checks++; if (px.size() != 3) begin errors++; $display("FAIL full_count got=%0d exp=3", px.size()); end
        checks++; if (px.size() == 3 && (px[0] !== 10'd0 || px[1] !== 10'd8 || px[2] !== 10'd16)) begin
            errors++; $display("FAIL full_order got=%0d,%0d,%0d exp=0,8,16", px[0], px[1], px[2]);
        end
        checks++; if (done_cnt != 1 || done_cyc != 10) begin errors++; $display("FAIL full_done got=cnt%0d@%0d exp=cnt1@10", done_cnt, done_cyc); end
    endtask

    task automatic test_full_last();
        clear_log();
        set_rect(0, 7, 0, 0, 4);
        for (int i = 0; i < 9; i++) begin
            start = (i == 0);
            full  = (i >= 2 && i <= 4);
            step();
        end
        full = 1'b0;
        checks++; if (px.size() != 1 || pcyc[0] != 5) begin errors++; $display("FAIL full_last_push got=%0d pushes exp=1@5", px.size()); end
        checks++; if (done_cnt != 1 || done_cyc != 6) begin errors++; $display("FAIL full_last_done got=cnt%0d@%0d exp=cnt1@6", done_cnt, done_cyc); end
    endtask

    task automatic test_reset_mid();
        int early;
        clear_log();
        set_rect(0, 31, 0, 31, 7);
        for (int i = 0; i < 5; i++) begin
            start   = (i == 0);
            reset_n = (i != 4);
            step();
        end
        reset_n = 1'b1;
        early = 0;
        foreach (pcyc[k]) if (pcyc[k] < 4) early++;
        checks++; if (early != 2) begin errors++; $display("FAIL rstmid_pre_pushes got=%0d exp=2", early); end
        clear_log();
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                checks++;
                if (s_push !== 1'b0 || s_busy !== 1'b0) begin
                    errors++; $display("FAIL rstmid_after got=push%b busy%b exp=push0 busy0", s_push, s_busy);
                end
            end
        end
        checks++; if (px.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL rstmid_abort got=%0d pushes %0d done exp=0 0", px.size(), done_cnt); end
        clear_log();
        set_rect(0, 15, 0, 15, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (px.size() != 4 || done_cnt != 1) begin errors++; $display("FAIL rstmid_restart got=%0d pushes %0d done exp=4 1", px.size(), done_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        set_rect(0, 7, 0, 7, 1);
        start = 1'b1;
        for (int i = 0; i < 8; i++) step();
        start = 1'b0;
        checks++; if (px.size() != 2 || pcyc[0] != 2 || pcyc[1] != 6) begin
            errors++; $display("FAIL b2b_pushes got=%0d pushes exp=2 at cycles 2,6", px.size());
        end
        checks++; if (done_cnt != 2 || done_cyc != 7) begin errors++; $display("FAIL b2b_done got=cnt%0d last@%0d exp=cnt2 last@7", done_cnt, done_cyc); end
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_clamp();
        test_invalid();
        test_full();
        test_full_last();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
